regfile_write_scheduler: RTL and testbench

- Sole owner of the register file write port (rd, rdAddress, rdWriteEnable); shares it among NUM_REQ writeback requesters (ALU, load unit, CSR unit, ...).
- Uses round-robin arbitration with a valid/ready handshake.
- Runs a zero-clear sequence after reset and on command, so a RAM-inferred register file without reset still starts at 0.
- Sits between the writeback sources and RegisterFile.

---
 rtl/regfile_write_scheduler_pkg.sv | 18 +
 rtl/regfile_write_scheduler_rr_arbiter.sv | 34 +++
 rtl/regfile_write_scheduler.sv | 145 ++++++++++++++
 tb/tb_regfile_write_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_scheduler_pkg.sv
// Shared types for the register file write scheduler: address type, FSM states
// and the last architectural register for each base ISA.
package JZJCoreFTypes;

    typedef logic [4:0] RegAddress_t;

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } SchedState_t;

    localparam RegAddress_t REG_ZERO = 5'd0;

    function automatic RegAddress_t lastRegister(input bit rv32i);
        return rv32i ? 5'd31 : 5'd15;
    endfunction

endpackage

// File: rtl/regfile_write_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after `last`, wrapping at N.
// Purely combinational; the caller owns and updates the last-grant index.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0]         request,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_index
);

    localparam int IW = $clog2(N);

    logic [IW:0] slot;

    // Scan from the farthest slot back to the nearest so the nearest valid wins.
    always_comb begin
        grant       = '0;
        grant_index = '0;
        slot        = '0;
        for (int off = N; off >= 1; off--) begin
            slot = {1'b0, last} + (IW + 1)'(off);
            if (slot >= (IW + 1)'(N)) begin
                slot = slot - (IW + 1)'(N);
            end
            if (request[slot[IW-1:0]]) begin
                grant                 = '0;
                grant[slot[IW-1:0]]   = 1'b1;
                grant_index           = slot[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Register file write-port owner: zero-clears x1..xLast, then round-robins NUM_REQ writers.
// Latency: one cycle grant-to-write. Backpressure: req_ready low during clear or clear_start.
// Optional REGFILE_SCHED_PERF_EN adds the saturating conflict_count output.
module regfile_write_scheduler
    import JZJCoreFTypes::*;
#(
    parameter bit RV32I   = 1'b1,
    parameter int NUM_REQ = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [5*NUM_REQ-1:0]   req_address,
    input  logic [32*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   clear_start,
    output logic                   clear_busy,
    output logic                   illegal_address,
    output logic [31:0]            rd,
    output logic [4:0]             rdAddress,
    output logic                   rdWriteEnable
`ifdef REGFILE_SCHED_PERF_EN
    ,
    output logic [31:0]            conflict_count
`endif
);

    localparam int          IW       = $clog2(NUM_REQ);
    localparam RegAddress_t LAST_REG = lastRegister(RV32I);

    SchedState_t state, state_next;
    RegAddress_t counter;
    logic [IW-1:0] rr_last;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      grant_index;
    logic               grant_vld;
    logic               clear_restart;

    RegAddress_t addr_arr [NUM_REQ];
    logic [31:0] data_arr [NUM_REQ];
    RegAddress_t sel_addr;
    logic [31:0] sel_data;
    logic        sel_illegal;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_address[5*i +: 5];
        assign data_arr[i] = req_data[32*i +: 32];
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .request     (req_valid),
        .last        (rr_last),
        .grant       (arb_grant),
        .grant_index (grant_index)
    );

    assign sel_addr    = addr_arr[grant_index];
    assign sel_data    = data_arr[grant_index];
    // On RV32E the upper half of the address space does not exist.
    assign sel_illegal = (RV32I == 1'b0) && sel_addr[4];
    assign clear_busy  = (state == CLEAR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        req_ready     = '0;
        grant_vld     = 1'b0;
        clear_restart = 1'b0;
        unique case (state)
            CLEAR: begin
                if (counter == LAST_REG) begin
                    state_next = ARB;
                end
            end
            ARB: begin
                if (clear_start) begin
                    state_next    = CLEAR;
                    clear_restart = 1'b1;
                end else begin
                    req_ready = arb_grant;
                    grant_vld = |req_valid;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter         <= 5'd1;
            rr_last         <= IW'(NUM_REQ - 1);
            rd              <= '0;
            rdAddress       <= REG_ZERO;
            rdWriteEnable   <= 1'b0;
            illegal_address <= 1'b0;
        end else begin
            rdWriteEnable   <= 1'b0;
            illegal_address <= 1'b0;
            if (state == CLEAR) begin
                rd            <= '0;
                rdAddress     <= counter;
                rdWriteEnable <= 1'b1;
                counter       <= counter + 5'd1;
            end else if (clear_restart) begin
                counter <= 5'd1;
            end else if (grant_vld) begin
                // x0 and out-of-range writes are consumed but never reach the file.
                rr_last         <= grant_index;
                rd              <= sel_data;
                rdAddress       <= sel_addr;
                rdWriteEnable   <= (sel_addr != REG_ZERO) && !sel_illegal;
                illegal_address <= sel_illegal;
            end
        end
    end

`ifdef REGFILE_SCHED_PERF_EN
    logic [31:0] conflict_cnt;
    logic        multi_valid;

    assign multi_valid    = (req_valid & (req_valid - NUM_REQ'(1))) != '0;
    assign conflict_count = conflict_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conflict_cnt <= '0;
        end else if (clear_restart) begin
            conflict_cnt <= '0;
        end else if ((state == ARB) && multi_valid && (conflict_cnt != 32'hFFFF_FFFF)) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench: RV32I instance for clear/arbitration/restart, RV32E instance for range checks.
module tb_regfile_write_scheduler;

    localparam logic [31:0] D0 = 32'h1111_0001;
    localparam logic [31:0] D1 = 32'h2222_0002;
    localparam logic [31:0] D2 = 32'h3333_0003;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [14:0] req_address;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        clear_start;
    logic        clear_busy;
    logic        illegal_address;
    logic [31:0] rd;
    logic [4:0]  rdAddress;
    logic        rdWriteEnable;
`ifdef REGFILE_SCHED_PERF_EN
    logic [31:0] conflict_count;
`endif

    logic        e_reset;
    logic [2:0]  e_req_valid;
    logic [14:0] e_req_address;
    logic [95:0] e_req_data;
    logic [2:0]  e_req_ready;
    logic        e_clear_start;
    logic        e_clear_busy;
    logic        e_illegal;
    logic [31:0] e_rd;
    logic [4:0]  e_rdAddress;
    logic        e_we;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] dv [3];
    logic [1:0]  g;

    always #5 clock = ~clock;

    regfile_write_scheduler #(.RV32I(1'b1), .NUM_REQ(3)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_address     (req_address),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .clear_start     (clear_start),
        .clear_busy      (clear_busy),
        .illegal_address (illegal_address),
        .rd              (rd),
        .rdAddress       (rdAddress),
        .rdWriteEnable   (rdWriteEnable)
`ifdef REGFILE_SCHED_PERF_EN
        ,
        .conflict_count  (conflict_count)
`endif
    );

    regfile_write_scheduler #(.RV32I(1'b0), .NUM_REQ(3)) dut_e (
        .clock           (clock),
        .reset           (e_reset),
        .req_valid       (e_req_valid),
        .req_address     (e_req_address),
        .req_data        (e_req_data),
        .req_ready       (e_req_ready),
        .clear_start     (e_clear_start),
        .clear_busy      (e_clear_busy),
        .illegal_address (e_illegal),
        .rd              (e_rd),
        .rdAddress       (e_rdAddress),
        .rdWriteEnable   (e_we)
`ifdef REGFILE_SCHED_PERF_EN
        ,
        .conflict_count  ()
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    initial begin
        dv[0] = D0;
        dv[1] = D1;
        dv[2] = D2;

        reset         = 1'b0;
        clear_start   = 1'b0;
        req_valid     = 3'b111;
        req_address   = {5'd5, 5'd5, 5'd5};
        req_data      = {D2, D1, D0};
        e_reset       = 1'b0;
        e_clear_start = 1'b0;
        e_req_valid   = 3'b000;
        e_req_address = '0;
        e_req_data    = '0;

        #2;
        chk("rst_rd", rd, 32'h0);
        chk("rst_addr", 32'(rdAddress), 32'd0);
        chk("rst_we", 32'(rdWriteEnable), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_illegal", 32'(illegal_address), 32'd0);
        chk("rst_busy", 32'(clear_busy), 32'd1);

        @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clock);
            chk("clr_addr", 32'(rdAddress), 32'(k));
            chk("clr_we", 32'(rdWriteEnable), 32'd1);
            chk("clr_rd", rd, 32'h0);
            if (k < 31) begin
                chk("clr_busy", 32'(clear_busy), 32'd1);
                chk("clr_ready", 32'(req_ready), 32'd0);
            end else begin
                chk("clr_done", 32'(clear_busy), 32'd0);
            end
        end

        // Rotation with all three requesters valid.
        g = 2'd0;
        for (int j = 0; j < 6; j++) begin
            chk("rot_ready", 32'(req_ready), 32'(3'b001 << g));
            @(negedge clock);
            chk("rot_rd", rd, dv[g]);
            chk("rot_addr", 32'(rdAddress), 32'd5);
            chk("rot_we", 32'(rdWriteEnable), 32'd1);
            g = (g == 2'd2) ? 2'd0 : g + 2'd1;
        end

        req_valid = 3'b000;
        #1;
        chk("idle_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        chk("idle_we", 32'(rdWriteEnable), 32'd0);
        chk("idle_rd_hold", rd, D2);
        chk("idle_addr_hold", 32'(rdAddress), 32'd5);

        // Write to x0 is granted but suppressed.
        req_address[9:5] = 5'd0;
        req_data[63:32]  = 32'hDEAD_BEEF;
        req_valid        = 3'b010;
        #1;
        chk("x0_ready", 32'(req_ready), 32'b010);
        @(negedge clock);
        req_valid = 3'b000;
        chk("x0_we", 32'(rdWriteEnable), 32'd0);
        chk("x0_illegal", 32'(illegal_address), 32'd0);

        // After granting 1, requester 2 precedes requester 0.
        req_address[4:0]   = 5'd7;
        req_address[14:10] = 5'd9;
        req_valid          = 3'b101;
        #1;
        chk("rr_ready_a", 32'(req_ready), 32'b100);
        @(negedge clock);
        chk("rr_addr_a", 32'(rdAddress), 32'd9);
        chk("rr_rd_a", rd, D2);
        chk("rr_we_a", 32'(rdWriteEnable), 32'd1);
        chk("rr_ready_b", 32'(req_ready), 32'b001);
        @(negedge clock);
        req_valid = 3'b000;
        chk("rr_addr_b", 32'(rdAddress), 32'd7);
        chk("rr_rd_b", rd, D0);

        // clear_start with requester 2 pending, restart ignored, then reset mid-clear.
        req_address[14:10] = 5'd12;
        req_valid          = 3'b100;
        clear_start        = 1'b1;
        #1;
        chk("cs_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        clear_start = 1'b0;
        chk("cs_busy", 32'(clear_busy), 32'd1);
        chk("cs_we", 32'(rdWriteEnable), 32'd0);
        chk("cs_ready2", 32'(req_ready), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            chk("cs_addr", 32'(rdAddress), 32'(k));
            chk("cs_clr_we", 32'(rdWriteEnable), 32'd1);
            chk("cs_clr_ready", 32'(req_ready), 32'd0);
            clear_start = (k == 2);
        end
        clear_start = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_addr", 32'(rdAddress), 32'd0);
        chk("mid_rst_we", 32'(rdWriteEnable), 32'd0);
        chk("mid_rst_busy", 32'(clear_busy), 32'd1);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clock);
            chk("re_addr", 32'(rdAddress), 32'(k));
            chk("re_we", 32'(rdWriteEnable), 32'd1);
            if (k < 31) begin
                chk("re_ready", 32'(req_ready), 32'd0);
            end else begin
                chk("re_busy", 32'(clear_busy), 32'd0);
                chk("re_first_ready", 32'(req_ready), 32'b100);
            end
        end
        @(negedge clock);
        req_valid = 3'b000;
        chk("re_first_addr", 32'(rdAddress), 32'd12);
        chk("re_first_rd", rd, D2);
        chk("re_first_we", 32'(rdWriteEnable), 32'd1);

`ifdef REGFILE_SCHED_PERF_EN
        chk("perf_start", conflict_count, 32'd0);
        req_valid = 3'b011;
        repeat (10) @(negedge clock);
        req_valid = 3'b000;
        chk("perf_count", conflict_count, 32'd10);
        clear_start = 1'b1;
        @(negedge clock);
        clear_start = 1'b0;
        chk("perf_cleared", conflict_count, 32'd0);
`endif

        // RV32E instance: 15-entry clear and out-of-range drop.
        @(negedge clock);
        e_reset = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            chk("e_clr_addr", 32'(e_rdAddress), 32'(k));
            chk("e_clr_we", 32'(e_we), 32'd1);
            chk("e_clr_busy", 32'(e_clear_busy), (k < 15) ? 32'd1 : 32'd0);
        end
        e_req_address[4:0] = 5'd20;
        e_req_data[31:0]   = 32'hCAFE_0014;
        e_req_valid        = 3'b001;
        #1;
        chk("e_ill_ready", 32'(e_req_ready), 32'b001);
        @(negedge clock);
        e_req_valid = 3'b000;
        chk("e_ill_we", 32'(e_we), 32'd0);
        chk("e_ill_pulse", 32'(e_illegal), 32'd1);
        @(negedge clock);
        chk("e_ill_end", 32'(e_illegal), 32'd0);
        e_req_address[9:5] = 5'd3;
        e_req_data[63:32]  = 32'h0BAD_0003;
        e_req_valid        = 3'b010;
        @(negedge clock);
        e_req_valid = 3'b000;
        chk("e_ok_addr", 32'(e_rdAddress), 32'd3);
        chk("e_ok_rd", e_rd, 32'h0BAD_0003);
        chk("e_ok_we", 32'(e_we), 32'd1);
        chk("e_ok_illegal", 32'(e_illegal), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
